// File: rtl/cnnip_mem_rd_streamer.sv
// rtl/cnnip_mem_rd_streamer.sv - credit-limited burst reader from block memory to a valid/ready word stream
// Issues sequential reads, counts in-flight words and buffers returns in a small FIFO.
module cnnip_mem_rd_streamer #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              start,
  input  logic [ADDR_WIDTH-1:0]             base_addr,
  input  logic [LEN_WIDTH-1:0]              len,
  output logic                              busy,
  output logic                              done,
  output logic                              err,
  output logic                              mem_en,
  output logic [((DATA_WIDTH-1)>>3):0]      mem_we,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic [DATA_WIDTH-1:0]             mem_din,
  input  logic [DATA_WIDTH-1:0]             mem_dout,
  input  logic                              mem_valid,
  output logic [DATA_WIDTH-1:0]             m_data,
  output logic                              m_valid,
  input  logic                              m_ready
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  base_r;
  logic [LEN_WIDTH-1:0]   len_r;
  logic [LEN_WIDTH-1:0]   issue_cnt;
  logic [CNT_W-1:0]       outstanding;
  logic [CNT_W-1:0]       fifo_count;
  logic [CNT_W-1:0]       fifo_count_nxt;
  logic [CNT_W:0]         inflight;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [DATA_WIDTH-1:0]  fifo_mem [FIFO_DEPTH];
  logic                   push;
  logic                   pop;
  logic                   err_set;
  logic                   last_issue;

  // Credit covers both buffered words and reads still in the memory pipeline.
  assign inflight   = {1'b0, fifo_count} + {1'b0, outstanding};
  assign mem_en     = (state == ISSUE) && (inflight < (CNT_W+1)'(FIFO_DEPTH));
  assign mem_addr   = base_r + ADDR_WIDTH'(issue_cnt);
  assign mem_we     = '0;
  assign mem_din    = '0;
  assign busy       = (state != IDLE);

  assign m_valid    = (fifo_count != '0);
  assign m_data     = fifo_mem[rd_ptr];

  assign push       = mem_valid && (outstanding != '0);
  assign pop        = m_valid && m_ready;
  assign err_set    = mem_valid && (outstanding == '0) && (state != IDLE);
  assign last_issue = mem_en && (issue_cnt == len_r - LEN_WIDTH'(1));

  assign fifo_count_nxt = fifo_count + CNT_W'(push) - CNT_W'(pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      base_r      <= '0;
      len_r       <= '0;
      issue_cnt   <= '0;
      outstanding <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            err <= 1'b0;
            if (len != '0) begin
              base_r    <= base_addr;
              len_r     <= len;
              issue_cnt <= '0;
              state     <= ISSUE;
            end else begin
              done <= 1'b0 | 1'b1;
            end
          end
        end
        ISSUE: begin
          if (mem_en) begin
            issue_cnt <= issue_cnt + LEN_WIDTH'(1);
            if (last_issue) state <= DRAIN;
          end
        end
        DRAIN: begin
          // Leave on the edge that pops the final word so done lines up with the stream end.
          if ((outstanding == '0) && (fifo_count_nxt == '0)) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (err_set) err <= 1'b1;

      case ({mem_en, push})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase

      if (push) begin
        fifo_mem[wr_ptr] <= mem_dout;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count <= fifo_count_nxt;
    end
  end

endmodule

// File: tb/tb_cnnip_mem_rd_streamer.sv
// tb/tb_cnnip_mem_rd_streamer.sv - directed bench for cnnip_mem_rd_streamer
// Latency-programmable memory model, in-order stream scoreboard and cycle-exact burst timing checks.
`timescale 1ns/1ps
module tb_cnnip_mem_rd_streamer;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int LW = 16;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] len = '0;
  logic          busy, done, err, mem_en, m_valid;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, m_data;
  logic [DW-1:0] mem_dout = '0;
  logic          mem_valid = 1'b0;
  logic          m_ready = 1'b0;

  cnnip_mem_rd_streamer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .err(err), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout), .mem_valid(mem_valid),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    return {a ^ 16'h5A5A, a};
  endfunction

  // Memory model: request seen in cycle c returns mem_valid in cycle c+lat.
  int            lat = 1;
  bit            ready_mode = 0;
  bit            ready_en = 0;
  bit            inject = 0;
  bit            rec_en = 0;
  bit [AW-1:0]   rec_addr = '0;
  bit            pv [4];
  bit [AW-1:0]   pa [4];

  always @(negedge clk) begin
    rec_en   = mem_en;
    rec_addr = mem_addr;
  end

  always @(posedge clk) begin
    #1;
    for (int i = 3; i > 0; i--) begin
      pv[i] = pv[i-1];
      pa[i] = pa[i-1];
    end
    pv[0]     = rec_en;
    pa[0]     = rec_addr;
    mem_valid = pv[lat-1] | inject;
    mem_dout  = inject ? 32'hDEAD_BEEF : word_of(pa[lat-1]);
    m_ready   = ready_mode ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : ready_en;
  end

  // Observation of cycle n happens at the negedge inside it, where cyc == n-1.
  logic [DW-1:0] exp_q [$];
  logic [AW-1:0] en_q [$];
  int  n_en, n_done, first_en, last_en, last_mv, done_cyc, issued, popped, max_inflight;
  bit  busy_seen, prev_stall;
  logic [DW-1:0] prev_data;

  task automatic clear_stats();
    n_en = 0; n_done = 0; first_en = 0; last_en = 0; last_mv = 0; done_cyc = 0;
    issued = 0; popped = 0; max_inflight = 0; busy_seen = 0; prev_stall = 0;
    en_q.delete();
  endtask

  always @(negedge clk) begin
    if (mem_en) begin
      n_en++;
      issued++;
      if (n_en == 1) first_en = cyc + 1;
      last_en = cyc + 1;
      en_q.push_back(mem_addr);
    end
    if (m_valid) last_mv = cyc + 1;
    if (done) begin
      n_done++;
      done_cyc = cyc + 1;
    end
    if (busy) busy_seen = 1;
    if (prev_stall) begin
      chk("stall_valid", m_valid, 1);
      chk("stall_data", m_data, prev_data);
    end
    if (m_valid && m_ready) begin
      popped++;
      if (exp_q.size() == 0) chk("extra_word", 1, 0);
      else chk("m_data", m_data, exp_q.pop_front());
    end
    if (issued - popped > max_inflight) max_inflight = issued - popped;
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
  end

  task automatic run_burst(input logic [AW-1:0] b, input logic [LW-1:0] n, input int l,
                           input bit rmode, input bit inj, input bit poke, input int exp_done);
    int t0;
    logic [AW-1:0] ea;
    lat = l; ready_mode = rmode; ready_en = 1;
    clear_stats();
    exp_q.delete();
    for (int i = 0; i < int'(n); i++) begin
      ea = b + 16'(i);
      exp_q.push_back(word_of(ea));
    end
    @(negedge clk); #1;
    start = 1; base_addr = b; len = n; inject = inj;
    @(posedge clk); #2;
    t0 = cyc;
    @(negedge clk); #1;
    start = 0; inject = 0;
    for (int i = 0; i < 300 && n_done == 0; i++) begin
      if (poke && i == 2) begin start = 1; base_addr = 16'h5555; len = 2; end
      if (poke && i == 3) start = 0;
      @(negedge clk); #1;
    end
    start = 0;
    chk("done_seen", (n_done > 0), 1);
    repeat (3) @(negedge clk);
    #1;
    chk("done_pulses", n_done, 1);
    chk("num_mem_en", n_en, n);
    for (int i = 0; i < en_q.size(); i++) begin
      ea = b + 16'(i);
      chk("mem_addr", en_q[i], ea);
    end
    chk("words_left", exp_q.size(), 0);
    chk("busy_end", busy, 0);
    chk("err_end", err, inj);
    chk("max_inflight_le_depth", (max_inflight <= FD), 1);
    if (exp_done >= 0) chk("done_cycle", done_cyc - t0, exp_done);
    if (n != 0 && !rmode) begin
      chk("first_en_cycle", first_en - t0, 1);
      chk("last_en_cycle", last_en - t0, n);
      chk("last_mvalid_cycle", last_mv - t0, n + l + 1);
    end
    if (n == 0) chk("busy_never_high", busy_seen, 0);
  endtask

  initial begin
    clear_stats();
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_din", mem_din, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    #1 rstn = 1;

    run_burst(16'h0010, 1, 1, 0, 0, 0, 4);
    run_burst(16'h0100, 8, 2, 0, 0, 0, 12);
    run_burst(16'h0100, 8, 2, 1, 0, 1, -1);
    run_burst(16'h0000, 0, 1, 0, 0, 0, 1);
    run_burst(16'hFFFE, 4, 1, 0, 0, 0, 7);
    run_burst(16'h0200, 4, 1, 0, 1, 0, 7);
    run_burst(16'h0300, 3, 1, 0, 0, 0, 6);

    // Reset mid-burst with reads still in the memory pipeline.
    lat = 3; ready_mode = 0; ready_en = 1;
    clear_stats();
    exp_q.delete();
    @(negedge clk); #1;
    start = 1; base_addr = 16'h0300; len = 8;
    @(negedge clk); #1;
    start = 0;
    repeat (2) @(negedge clk);
    #1 rstn = 0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_mem_en", mem_en, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_m_data", m_data, 0);
    #1 rstn = 1;
    repeat (6) @(negedge clk);
    #1;
    chk("late_valid_err", err, 0);
    chk("late_valid_m_valid", m_valid, 0);
    chk("late_valid_busy", busy, 0);
    chk("late_valid_popped", popped, 0);

    run_burst(16'h0400, 5, 2, 0, 0, 0, 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
